// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the APB timer: register offsets, CTRL/STATUS bit positions, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package timer_ctrl_pkg;

  // Register byte offsets
  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_LOAD   = 4'h4;
  localparam logic [3:0] ADDR_COUNT  = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  // CTRL bit positions
  localparam int CTRL_EN        = 0;
  localparam int CTRL_AUTO      = 1;
  localparam int CTRL_SRC       = 2;
  localparam int CTRL_IE        = 3;
  localparam int CTRL_PRESC_LSB = 8;

  // STATUS bit positions
  localparam int STAT_PEND    = 0;
  localparam int STAT_RUNNING = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/timer_tick_gen.sv
// Tick source for the timer: PRESC+1 divider of clk, or a synchronized ext_tick rising edge.
// Latency: prescaled tick is combinational from the divider state; ext_tick edges appear 2 clk after capture.
// Backpressure: none; ticks are dropped unless run is high.
//
// Ports: clk/rst (sync active-high), clr clears the divider, run enables counting,
// src selects ext_tick (only with TIMER_CTRL_EXT_TICK_EN), presc divider value,
// ext_tick asynchronous input, tick single-cycle output pulse.
// Macro TIMER_CTRL_EXT_TICK_EN: adds the ext_tick synchronizer/edge detector.
module timer_tick_gen #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               run,
  input  logic               src,
  input  logic [PRESC_W-1:0] presc,
  input  logic               ext_tick,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt;
  logic               presc_tick;
  logic               use_ext;
  logic               ext_edge;

`ifdef TIMER_CTRL_EXT_TICK_EN
  // [0],[1] form the synchronizer; [2] holds the previous synchronized value for edge detect.
  logic [2:0] ext_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_sync <= '0;
    end else begin
      ext_sync <= {ext_sync[1:0], ext_tick};
    end
  end

  assign use_ext  = src;
  assign ext_edge = ext_sync[1] & ~ext_sync[2];
`else
  logic unused_ext;
  assign unused_ext = ext_tick ^ src;
  assign use_ext    = 1'b0;
  assign ext_edge   = 1'b0;
`endif

  assign presc_tick = (presc_cnt == presc);

  // Divider only advances while it is the selected source, so switching
  // back to PCLK resumes from where it stopped.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc_cnt <= '0;
    end else if (run && !use_ext) begin
      presc_cnt <= presc_tick ? '0 : presc_cnt + 1'b1;
    end
  end

  assign tick = run & (use_ext ? ext_edge : presc_tick);

endmodule

// File: rtl/timer_ctrl.sv
// APB down-counting timer with one-shot/auto-reload modes and a registered level interrupt.
// Latency: zero-wait-state APB; interrupt follows PEND/IE by one PCLK.
// Backpressure: none; PREADY is tied high.
//
// Ports: PCLK, rst (sync active-high), APB slave (PSEL, PENABLE, PWRITE, PADDR,
// PWDATA, PRDATA, PREADY, PSLVERR), ext_tick (async count source), timer_interrupt.
// Macro TIMER_CTRL_EXT_TICK_EN: enables CTRL.SRC and the ext_tick path; otherwise SRC reads 0.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic        PCLK,
  input  logic        rst,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        ext_tick,
  output logic        timer_interrupt
);

  logic               access;
  logic               bus_err;
  logic               wr_ok;
  logic               wr_ctrl;
  logic               wr_load;
  logic               wr_status;
  logic               en_rise;

  logic               ctrl_en;
  logic               ctrl_auto;
  logic               ctrl_src;
  logic               ctrl_ie;
  logic [PRESC_W-1:0] ctrl_presc;
  logic [CNT_W-1:0]   load_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_nxt;
  logic               pend_q;
  logic               irq_q;

  state_t             state;
  state_t             state_nxt;
  logic               run;
  logic               tick;
  logic               expire;
  logic               running;
  logic [31:0]        rdata;

  // ---------------- APB decode ----------------
  assign access    = PSEL & PENABLE;
  assign bus_err   = (PADDR[1:0] != 2'b00) | (PWRITE & (PADDR == ADDR_COUNT));
  assign PSLVERR   = access & bus_err & ~rst;
  assign PREADY    = 1'b1;
  assign wr_ok     = access & PWRITE & ~bus_err;
  assign wr_ctrl   = wr_ok & (PADDR == ADDR_CTRL);
  assign wr_load   = wr_ok & (PADDR == ADDR_LOAD);
  assign wr_status = wr_ok & (PADDR == ADDR_STATUS);
  assign en_rise   = wr_ctrl & PWDATA[CTRL_EN] & ~ctrl_en;

  // Ticks are ignored in the single cycle between EN going low and RUN->IDLE,
  // so COUNT holds the value it had when software stopped the timer.
  assign run     = (state == ST_RUN) & ctrl_en;
  assign running = (state == ST_LOAD) | (state == ST_RUN);

  timer_tick_gen #(
    .PRESC_W (PRESC_W)
  ) u_tick_gen (
    .clk      (PCLK),
    .rst      (rst),
    .clr      (state == ST_LOAD),
    .run      (run),
    .src      (ctrl_src),
    .presc    (ctrl_presc),
    .ext_tick (ext_tick),
    .tick     (tick)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge PCLK) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count_q;
    expire    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (en_rise) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt = ST_RUN;
        count_nxt = load_q;
      end
      ST_RUN: begin
        // en_rise here means EN was cleared last cycle and set again: restart.
        if (en_rise) begin
          state_nxt = ST_LOAD;
        end else if (!ctrl_en) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          if (count_q == '0) begin
            expire = 1'b1;
            if (ctrl_auto) count_nxt = load_q;
            else           state_nxt = ST_DONE;
          end else begin
            count_nxt = count_q - 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- Registers ----------------
  always_ff @(posedge PCLK) begin
    if (rst) begin
      ctrl_en    <= 1'b0;
      ctrl_auto  <= 1'b0;
      ctrl_ie    <= 1'b0;
      ctrl_presc <= '0;
      load_q     <= '0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      count_q <= count_nxt;
      if (wr_ctrl) begin
        ctrl_en    <= PWDATA[CTRL_EN];
        ctrl_auto  <= PWDATA[CTRL_AUTO];
        ctrl_ie    <= PWDATA[CTRL_IE];
        ctrl_presc <= PWDATA[CTRL_PRESC_LSB +: PRESC_W];
      end
      // One-shot expiry clears EN even over a same-cycle software write.
      if (expire && !ctrl_auto) ctrl_en <= 1'b0;
      if (wr_load) load_q <= PWDATA[CNT_W-1:0];
      // Expiry wins over a simultaneous W1C so no event is lost.
      pend_q <= (pend_q & ~(wr_status & PWDATA[STAT_PEND])) | expire;
      irq_q  <= pend_q & ctrl_ie;
    end
  end

`ifdef TIMER_CTRL_EXT_TICK_EN
  always_ff @(posedge PCLK) begin
    if (rst) begin
      ctrl_src <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_src <= PWDATA[CTRL_SRC];
    end
  end
`else
  assign ctrl_src = 1'b0;
`endif

  assign timer_interrupt = irq_q;

  // ---------------- Read mux ----------------
  always_comb begin
    rdata = '0;
    case (PADDR)
      ADDR_CTRL: begin
        rdata[CTRL_EN]                        = ctrl_en;
        rdata[CTRL_AUTO]                      = ctrl_auto;
        rdata[CTRL_SRC]                       = ctrl_src;
        rdata[CTRL_IE]                        = ctrl_ie;
        rdata[CTRL_PRESC_LSB +: PRESC_W]      = ctrl_presc;
      end
      ADDR_LOAD:   rdata[CNT_W-1:0] = load_q;
      ADDR_COUNT:  rdata[CNT_W-1:0] = count_q;
      ADDR_STATUS: begin
        rdata[STAT_PEND]    = pend_q;
        rdata[STAT_RUNNING] = running;
      end
      default:     rdata = '0;
    endcase
  end

  assign PRDATA = (access & ~PWRITE) ? rdata : '0;

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

  logic        PCLK = 1'b0;
  logic        rst = 1'b1;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [3:0]  PADDR = 4'h0;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        ext_tick = 1'b0;
  logic        timer_interrupt;

  int checks = 0;
  int errors = 0;

  logic [31:0] d;
  logic        e;
  logic        r;

  always #5 PCLK = ~PCLK;

  timer_ctrl dut (
    .PCLK            (PCLK),
    .rst             (rst),
    .PSEL            (PSEL),
    .PENABLE         (PENABLE),
    .PWRITE          (PWRITE),
    .PADDR           (PADDR),
    .PWDATA          (PWDATA),
    .PRDATA          (PRDATA),
    .PREADY          (PREADY),
    .PSLVERR         (PSLVERR),
    .ext_tick        (ext_tick),
    .timer_interrupt (timer_interrupt)
  );

  // Called at a negedge; commits on the next posedge and returns at the following negedge.
  task automatic wr(input logic [3:0] a, input logic [31:0] v, output logic err);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = v;
    #1 err = PSLVERR;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge PCLK);
  endtask

  // Zero-time-ish read between clock edges; no state is affected.
  task automatic rd(input logic [3:0] a, output logic [31:0] v, output logic err, output logic rdy);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
    #1 v = PRDATA; err = PSLVERR; rdy = PREADY;
    PSEL = 1'b0; PENABLE = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL rst_idle_prdata: got %h exp %h", PRDATA, 32'h0); end
    checks++; if (timer_interrupt !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b exp 0", timer_interrupt); end
    rd(4'h0, d, e, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h exp %h", d, 32'h0); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b exp 0", e); end
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL rst_pready: got %b exp 1", r); end
    rd(4'h4, d, e, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_load: got %h exp %h", d, 32'h0); end
    rd(4'h8, d, e, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_count: got %h exp %h", d, 32'h0); end
    @(negedge PCLK);
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %h exp %h", d, 32'h0); end
  endtask

  task automatic test_auto_reload();
    logic [31:0] exp_cnt [9] = '{3, 2, 1, 0, 3, 2, 1, 0, 3};
    logic        exp_pnd [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    logic        exp_irq [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    do_reset();
    wr(4'h4, 32'd3, e);
    wr(4'h0, 32'h0B, e);
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL auto_load_running: got %h exp %h", d, 32'h2); end
    for (int i = 0; i < 9; i++) begin
      @(negedge PCLK);
      rd(4'h8, d, e, r);
      checks++; if (d !== exp_cnt[i]) begin errors++; $display("FAIL auto_count[%0d]: got %0d exp %0d", i, d, exp_cnt[i]); end
      rd(4'hC, d, e, r);
      checks++; if (d[0] !== exp_pnd[i]) begin errors++; $display("FAIL auto_pend[%0d]: got %b exp %b", i, d[0], exp_pnd[i]); end
      checks++; if (timer_interrupt !== exp_irq[i]) begin errors++; $display("FAIL auto_irq[%0d]: got %b exp %b", i, timer_interrupt, exp_irq[i]); end
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    wr(4'h4, 32'd2, e);
    wr(4'h0, 32'h401, e);
    repeat (5) @(negedge PCLK);
    rd(4'h8, d, e, r);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL oneshot_cnt_pre: got %0d exp 2", d); end
    @(negedge PCLK);
    rd(4'h8, d, e, r);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL oneshot_cnt_first_tick: got %0d exp 1", d); end
    repeat (9) @(negedge PCLK);
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL oneshot_status_14: got %h exp %h", d, 32'h2); end
    @(negedge PCLK);
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL oneshot_status_15: got %h exp %h", d, 32'h1); end
    rd(4'h0, d, e, r);
    checks++; if (d !== 32'h400) begin errors++; $display("FAIL oneshot_ctrl_en_cleared: got %h exp %h", d, 32'h400); end
    repeat (3) @(negedge PCLK);
    rd(4'h8, d, e, r);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL oneshot_count_hold: got %0d exp 0", d); end
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL oneshot_done_status: got %h exp %h", d, 32'h1); end
  endtask

  task automatic test_w1c_race();
    do_reset();
    wr(4'h4, 32'd3, e);
    wr(4'h0, 32'h0B, e);
    repeat (4) @(negedge PCLK);
    wr(4'hC, 32'h1, e);   // commits on the expiry edge
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL w1c_race_pend: got %h exp %h", d, 32'h3); end
    wr(4'hC, 32'h1, e);
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL w1c_clear_pend: got %h exp %h", d, 32'h2); end
    @(negedge PCLK);
    checks++; if (timer_interrupt !== 1'b0) begin errors++; $display("FAIL w1c_irq_low: got %b exp 0", timer_interrupt); end
  endtask

  task automatic test_bus_errors();
    do_reset();
    wr(4'h4, 32'h55, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL err_good_write: got %b exp 0", e); end
    wr(4'h0, 32'h0A, e);
    rd(4'h6, d, e, r);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_read_0x6: got %b exp 1", e); end
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL err_pready: got %b exp 1", r); end
    wr(4'h8, 32'h1234, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_write_count: got %b exp 1", e); end
    wr(4'h1, 32'h0, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_write_0x1: got %b exp 1", e); end
    wr(4'h5, 32'hFF, e);
    wr(4'hD, 32'h0, e);
    rd(4'h0, d, e, r);
    checks++; if (d !== 32'h0A) begin errors++; $display("FAIL err_ctrl_kept: got %h exp %h", d, 32'h0A); end
    rd(4'h4, d, e, r);
    checks++; if (d !== 32'h55) begin errors++; $display("FAIL err_load_kept: got %h exp %h", d, 32'h55); end
    @(negedge PCLK);
    rd(4'h8, d, e, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL err_count_kept: got %h exp %h", d, 32'h0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(4'h4, 32'd7, e);
    wr(4'h0, 32'h09, e);
    repeat (3) @(negedge PCLK);
    rd(4'h8, d, e, r);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL rmid_count_pre: got %0d exp 5", d); end
    rst = 1'b1;
    @(negedge PCLK);
    rd(4'h8, d, e, r);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rmid_count: got %0d exp 0", d); end
    rd(4'h0, d, e, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rmid_ctrl: got %h exp 0", d); end
    @(negedge PCLK);
    rd(4'h4, d, e, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rmid_load: got %h exp 0", d); end
    rd(4'h6, d, e, r);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rmid_pslverr: got %b exp 0", e); end
    rst = 1'b0;
    repeat (6) @(negedge PCLK);
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rmid_status_after: got %h exp 0", d); end
    checks++; if (timer_interrupt !== 1'b0) begin errors++; $display("FAIL rmid_irq: got %b exp 0", timer_interrupt); end
  endtask

  task automatic test_reload_update();
    do_reset();
    wr(4'h4, 32'd3, e);
    wr(4'h0, 32'h0B, e);
    @(negedge PCLK);
    wr(4'h4, 32'd5, e);
    rd(4'h8, d, e, r);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL upd_load_no_effect: got %0d exp 2", d); end
    wr(4'h0, 32'h03, e);
    rd(4'h8, d, e, r);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL upd_ctrl_no_restart: got %0d exp 1", d); end
    @(negedge PCLK);
    rd(4'h8, d, e, r);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL upd_count_zero: got %0d exp 0", d); end
    @(negedge PCLK);
    rd(4'h8, d, e, r);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL upd_new_reload: got %0d exp 5", d); end
    wr(4'h0, 32'h0, e);
    rd(4'h8, d, e, r);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL stop_count: got %0d exp 4", d); end
    @(negedge PCLK);
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL stop_status: got %h exp %h", d, 32'h1); end
    @(negedge PCLK);
    rd(4'h8, d, e, r);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL stop_count_hold: got %0d exp 4", d); end
    checks++; if (timer_interrupt !== 1'b0) begin errors++; $display("FAIL stop_irq_ie_off: got %b exp 0", timer_interrupt); end
  endtask

  task automatic test_load_zero();
    do_reset();
    wr(4'h4, 32'd0, e);
    wr(4'h0, 32'h03, e);
    @(negedge PCLK);
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL lz_pre: got %h exp %h", d, 32'h2); end
    @(negedge PCLK);
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL lz_first_tick: got %h exp %h", d, 32'h3); end
    wr(4'hC, 32'h1, e);
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL lz_w1c_loses: got %h exp %h", d, 32'h3); end
  endtask

  task automatic test_ext_tick();
    do_reset();
`ifdef TIMER_CTRL_EXT_TICK_EN
    wr(4'h4, 32'd1, e);
    wr(4'h0, 32'h05, e);
    repeat (3) @(negedge PCLK);
    rd(4'h0, d, e, r);
    checks++; if (d !== 32'h05) begin errors++; $display("FAIL ext_ctrl_src: got %h exp %h", d, 32'h05); end
    ext_tick = 1'b1; repeat (2) @(negedge PCLK); ext_tick = 1'b0; repeat (4) @(negedge PCLK);
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ext_after_one: got %h exp %h", d, 32'h2); end
    ext_tick = 1'b1; repeat (2) @(negedge PCLK); ext_tick = 1'b0; repeat (4) @(negedge PCLK);
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL ext_after_two: got %h exp %h", d, 32'h1); end
`else
    wr(4'h0, 32'h04, e);
    rd(4'h0, d, e, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL nosrc_readback: got %h exp 0", d); end
    wr(4'h4, 32'd1, e);
    wr(4'h0, 32'hFF05, e);
    rd(4'h0, d, e, r);
    checks++; if (d !== 32'hFF01) begin errors++; $display("FAIL nosrc_ctrl: got %h exp %h", d, 32'hFF01); end
    for (int i = 0; i < 2; i++) begin
      ext_tick = 1'b1; repeat (2) @(negedge PCLK); ext_tick = 1'b0; repeat (3) @(negedge PCLK);
    end
    rd(4'hC, d, e, r);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL nosrc_ext_ignored: got %h exp %h", d, 32'h2); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    @(negedge PCLK);
    test_reset();
    test_auto_reload();
    test_oneshot();
    test_w1c_race();
    test_bus_errors();
    test_reset_mid();
    test_reload_update();
    test_load_zero();
    test_ext_tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
